// File: rtl/branch_unit.sv
// Branch resolution unit: decodes conditional branches in EX, resolves them against
// forwarded operands, and trains a table of 2-bit saturating predictors indexed by PC.
module branch_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BHT_DEPTH = 16,
   parameter logic [1:0]  CNT_INIT  = 2'b01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [WIDTH-1:0] if_pc,
   output logic             if_pred_taken,
   input  logic             ex_valid,
   input  logic [5:0]       ex_opcode,
   input  logic [4:0]       ex_rt,
   input  logic [WIDTH-1:0] ex_in1,
   input  logic [WIDTH-1:0] ex_in2,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic             ex_pred_taken,
   output logic             is_cond_branch,
   output logic             is_branch,
   output logic             mispredict,
   output logic [31:0]      branch_count,
   output logic [31:0]      mispredict_count
);

   localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

   typedef enum logic [5:0] {
      OP_REGIMM = 6'b000001,
      OP_BEQ    = 6'b000100,
      OP_BNE    = 6'b000101,
      OP_BLEZ   = 6'b000110,
      OP_BGTZ   = 6'b000111
   } opcode_e;

   logic [1:0]       r_bht [BHT_DEPTH];
   logic [31:0]      r_branch_count;
   logic [31:0]      r_mispredict_count;

   logic [IDX_W-1:0] w_if_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_eq;
   logic             w_neg;
   logic             w_zero;
   logic             w_cond;
   logic             w_taken;
   logic             w_mispredict;
   logic             w_update;
   logic [1:0]       w_ctr;
   logic [1:0]       w_ctr_next;
   logic             w_unused;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_ex_idx = ex_pc[IDX_W+1:2];
   // Only the index bits of the PCs participate; the rest is deliberately ignored.
   assign w_unused = ^{if_pc, ex_pc};

   assign w_eq   = (ex_in1 == ex_in2);
   assign w_neg  = ex_in1[WIDTH-1];
   assign w_zero = (ex_in1 == '0);

   always_comb begin
      w_cond  = 1'b0;
      w_taken = 1'b0;
      if (ex_valid) begin
         case (ex_opcode)
            OP_BEQ:  begin w_cond = 1'b1; w_taken = w_eq;              end
            OP_BNE:  begin w_cond = 1'b1; w_taken = !w_eq;             end
            OP_BLEZ: begin w_cond = 1'b1; w_taken = w_neg || w_zero;   end
            OP_BGTZ: begin w_cond = 1'b1; w_taken = !w_neg && !w_zero; end
            OP_REGIMM: begin
               if (ex_rt == 5'b00000) begin
                  w_cond  = 1'b1;
                  w_taken = w_neg;
               end else if (ex_rt == 5'b00001) begin
                  w_cond  = 1'b1;
                  w_taken = !w_neg;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_mispredict = w_cond && (w_taken ^ ex_pred_taken);
   assign w_update     = w_cond && !stall;

   always_comb begin
      w_ctr      = r_bht[w_ex_idx];
      w_ctr_next = w_ctr;
      if (w_taken) begin
         if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
      end else begin
         if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_INIT;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (w_update) begin
         r_bht[w_ex_idx] <= w_ctr_next;
         if (r_branch_count != '1) r_branch_count <= r_branch_count + 32'd1;
         if (w_mispredict && (r_mispredict_count != '1))
            r_mispredict_count <= r_mispredict_count + 32'd1;
      end
   end

   // Lookup reads the registered table, so a same-index update shows up next cycle.
   assign if_pred_taken    = r_bht[w_if_idx][1];
   assign is_cond_branch   = w_cond;
   assign is_branch        = w_taken;
   assign mispredict       = w_mispredict;
   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a reference model queues expected outputs per
// vector; a negedge monitor pops and compares them against the DUT.
module tb_branch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, ex_valid, ex_pred_taken;
   logic [31:0] if_pc, ex_in1, ex_in2, ex_pc;
   logic [5:0]  ex_opcode;
   logic [4:0]  ex_rt;
   logic        if_pred_taken, is_cond_branch, is_branch, mispredict;
   logic [31:0] branch_count, mispredict_count;

   always #5 clk = ~clk;

   branch_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_INIT(2'b01)) dut (
      .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc),
      .if_pred_taken(if_pred_taken), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_rt(ex_rt), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .is_cond_branch(is_cond_branch),
      .is_branch(is_branch), .mispredict(mispredict),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   typedef struct {
      string       tag;
      logic        cond, br, mp, pred;
      logic [31:0] bc, mc;
   } exp_t;

   exp_t        q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [1:0]  m_bht [16];
   logic [31:0] m_bc, m_mc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] ref_dec(input logic v, input logic [5:0] op,
                                          input logic [4:0] rt, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      if (!v) return 2'b00;
      case (op)
         6'd4: return {1'b1, a == b};
         6'd5: return {1'b1, a != b};
         6'd6: return {1'b1, sa <= 0};
         6'd7: return {1'b1, sa > 0};
         6'd1: begin
            if (rt == 5'd0) return {1'b1, sa < 0};
            if (rt == 5'd1) return {1'b1, sa >= 0};
            return 2'b00;
         end
         default: return 2'b00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
      m_bc = '0;
      m_mc = '0;
   endtask

   task automatic vec(input string tag, input logic [5:0] op, input logic [4:0] rt,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] epc,
                      input logic ept, input logic [31:0] ipc, input logic stl = 1'b0,
                      input logic rst = 1'b0, input logic v = 1'b1);
      exp_t       e;
      logic [1:0] d;
      int         xi;
      @(posedge clk);
      #1;
      reset = rst; stall = stl; ex_valid = v; ex_opcode = op; ex_rt = rt;
      ex_in1 = a; ex_in2 = b; ex_pc = epc; ex_pred_taken = ept; if_pc = ipc;
      d      = ref_dec(v, op, rt, a, b);
      e.tag  = tag;
      e.cond = d[1];
      e.br   = d[0];
      e.mp   = d[1] & (d[0] ^ ept);
      e.pred = m_bht[ipc[5:2]][1];
      e.bc   = m_bc;
      e.mc   = m_mc;
      q.push_back(e);
      xi = int'(epc[5:2]);
      if (rst) model_reset();
      else if (!stl && d[1]) begin
         if (d[0] && m_bht[xi] != 2'b11) m_bht[xi] = m_bht[xi] + 2'b01;
         if (!d[0] && m_bht[xi] != 2'b00) m_bht[xi] = m_bht[xi] - 2'b01;
         if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
         if (e.mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      end
   endtask

   task automatic nop(input string tag, input logic [31:0] ipc);
      vec(tag, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ipc);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check({e.tag, ".cond"}, {31'd0, is_cond_branch}, {31'd0, e.cond});
         check({e.tag, ".br"},   {31'd0, is_branch},      {31'd0, e.br});
         check({e.tag, ".mp"},   {31'd0, mispredict},     {31'd0, e.mp});
         check({e.tag, ".pred"}, {31'd0, if_pred_taken},  {31'd0, e.pred});
         check({e.tag, ".bc"},   branch_count,            e.bc);
         check({e.tag, ".mc"},   mispredict_count,        e.mc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] pool [6];
      logic [5:0]  ops  [8];
      reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_rt = '0;
      ex_in1 = '0; ex_in2 = '0; ex_pc = '0; ex_pred_taken = 1'b0; if_pc = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 16; i++) nop("rst_pred", 32'(i * 4));

      vec("beq_eq", 6'd4, 5'd0, 32'd5, 32'd5, 32'h40, 1'b0, 32'h40);
      nop("beq_after", 32'h40);

      vec("bltz_min",  6'd1, 5'd0, 32'h8000_0000, 32'd0, 32'h08, 1'b0, 32'h08);
      vec("blez_min",  6'd6, 5'd0, 32'h8000_0000, 32'd0, 32'h0C, 1'b1, 32'h08);
      vec("bgtz_zero", 6'd7, 5'd0, 32'd0,         32'd0, 32'h0C, 1'b1, 32'h0C);
      vec("bgez_zero", 6'd1, 5'd1, 32'd0,         32'd0, 32'h14, 1'b1, 32'h14);
      vec("bgtz_max",  6'd7, 5'd0, 32'h7FFF_FFFF, 32'd0, 32'h18, 1'b0, 32'h18);
      vec("regimm_rt2",6'd1, 5'd2, 32'h8000_0000, 32'd0, 32'h1C, 1'b0, 32'h1C);
      vec("bne_eq",    6'd5, 5'd0, 32'd9,         32'd9, 32'h20, 1'b1, 32'h20);
      vec("bne_ne",    6'd5, 5'd0, 32'd9,         32'd8, 32'h24, 1'b0, 32'h24);
      vec("beq_ne",    6'd4, 5'd0, 32'd1,         32'd2, 32'h28, 1'b0, 32'h28);
      nop("decode_after", 32'h08);

      for (int i = 0; i < 5; i++)
         vec("sat_up", 6'd4, 5'd0, 32'd3, 32'd3, 32'h10, 1'b1, 32'h10);
      for (int i = 0; i < 4; i++)
         vec("sat_dn", 6'd4, 5'd0, 32'd3, 32'd4, 32'h10, 1'b0, 32'h10);
      nop("sat_after", 32'h10);

      vec("same_idx", 6'd4, 5'd0, 32'd7, 32'd7, 32'h30, 1'b1, 32'h30);
      nop("same_idx_next", 32'h30);

      vec("stall_br", 6'd4, 5'd0, 32'd1, 32'd1, 32'h34, 1'b0, 32'h34, 1'b1);
      vec("invalid",  6'd4, 5'd0, 32'd1, 32'd1, 32'h34, 1'b0, 32'h34, 1'b0, 1'b0, 1'b0);
      nop("stall_after", 32'h34);
      vec("rst_upd", 6'd4, 5'd0, 32'd1, 32'd1, 32'h30, 1'b0, 32'h30, 1'b1, 1'b1);
      vec("rst_upd2", 6'd4, 5'd0, 32'd1, 32'd1, 32'h30, 1'b0, 32'h30, 1'b0, 1'b1);
      nop("rst_after", 32'h30);

      vec("alias_upd", 6'd4, 5'd0, 32'd2, 32'd2, 32'h00, 1'b0, 32'h40);
      nop("alias_40", 32'h40);
      nop("alias_04", 32'h04);

      pool[0] = 32'd0;         pool[1] = 32'd1;          pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;  pool[5] = 32'd0;
      ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd6; ops[3] = 6'd7;
      ops[4] = 6'd1; ops[5] = 6'd1; ops[6] = 6'd0; ops[7] = 6'd8;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b;
         pool[5] = $urandom;
         a = pool[$urandom_range(0, 5)];
         b = ($urandom_range(0, 2) == 0) ? a : pool[$urandom_range(0, 5)];
         vec("rand", ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), a, b,
             32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0));
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) check("drain", 32'(q.size()), 32'd0);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
